// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule and round datapath.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic {StIdle, StEmit} ks_state_e;

  // Forward S-box; element 0 sits in the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8); steps rcon through 01,02,...,80,1b,36.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    logic [7:0] sh;
    sh = {r[6:0], 1'b0};
    return r[7] ? (sh ^ 8'h1b) : sh;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational byte substitution, shared by key schedule and round datapath.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one 128-bit round-key register, one round key per beat.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  localparam logic [3:0] LastIdx = NR[3:0];

  ks_state_e  state_q, state_d;
  rkey_t      rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;

  word_t w0, w1, w2, w3;
  word_t rot_word, sub_word, t_word;
  word_t n0, n1, n2, n3;
  rkey_t rk_next;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot_word[8*g +: 8]),
      .sub  (sub_word[8*g +: 8])
    );
  end

  // Next round key: S-box on rotated w3, then the 4-word XOR chain.
  always_comb begin
    t_word  = sub_word ^ {rcon_q, 24'h0};
    n0      = w0 ^ t_word;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    n3      = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

  // Handshake FSM and round-key / index / rcon update.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      StIdle: begin
        if (key_valid) begin
          rk_d    = key;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (rk_ready) begin
          if (idx_q == LastIdx) begin
            // Final beat: rk and rk_idx keep their last values.
            state_d = StIdle;
          end else begin
            rk_d   = rk_next;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort to reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign key_ready = (state_q == StIdle);
  assign busy      = (state_q == StEmit);
  assign rk_valid  = busy;
  assign rk        = rk_q;
  assign rk_idx    = idx_q;
  assign rk_last   = rk_valid && (idx_q == LastIdx);

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_rk [11];
  logic [127:0] key_a;
  logic [127:0] key_b;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key_ready"}, key_ready, 1);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_rk"}, rk, 0);
    chk({tag, "_rk_idx"}, rk_idx, 0);
    chk({tag, "_rk_last"}, rk_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called at a negedge while idle; returns at the negedge after acceptance.
  task automatic present_key(input logic [127:0] k);
    chk("pre_key_ready", key_ready, 1);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Walk the 11 beats of key_a against the table, optionally stalling and poking key_valid.
  task automatic stream(input string tag, input int stall_pct, input bit poke);
    int e   = 0;
    int cyc = 0;
    while (e <= 10 && cyc < 400) begin
      chk({tag, "_rk_valid"}, rk_valid, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_key_ready"}, key_ready, 0);
      chk({tag, "_rk_idx"}, rk_idx, 128'(e));
      chk({tag, "_rk"}, rk, exp_rk[e]);
      chk({tag, "_rk_last"}, rk_last, (e == 10) ? 1 : 0);
      rk_ready = ($urandom_range(99) >= stall_pct);
      if (poke) begin
        key_valid = 1'($urandom_range(1));
        key       = ~exp_rk[e];
      end
      @(negedge clk);
      cyc++;
      if (rk_ready) e++;
    end
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    chk({tag, "_beats_done"}, 128'(e), 128'(11));
    if (stall_pct == 0) chk({tag, "_period"}, 128'(cyc), 128'(11));
    chk({tag, "_end_key_ready"}, key_ready, 1);
    chk({tag, "_end_rk_valid"}, rk_valid, 0);
    chk({tag, "_end_rk_last"}, rk_last, 0);
    chk({tag, "_end_rk_idx_hold"}, rk_idx, 10);
    chk({tag, "_end_rk_hold"}, rk, exp_rk[10]);
  endtask

  initial begin
    exp_rk[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    exp_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    exp_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    exp_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    exp_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    exp_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    exp_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    exp_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    exp_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    exp_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    exp_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    key_a = exp_rk[0];
    key_b = 128'h0f1571c9_47d9e859_0cb7add6_af7f6798;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    rk_ready  = 1'b0;

    // Reset state.
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_release");

    // FIPS-197 key, consumer always ready.
    rk_ready = 1'b1;
    present_key(key_a);
    stream("fips", 0, 1'b0);

    // Backpressure with stray key_valid pulses carrying a different key.
    present_key(key_a);
    stream("stall", 50, 1'b1);

    // Asynchronous reset while round key 5 is presented.
    present_key(key_a);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("pre_abort_idx", rk_idx, 5);
    chk("pre_abort_rk", rk, exp_rk[5]);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_abort");
    present_key(key_a);
    stream("restart", 0, 1'b0);

    // Back-to-back: key_valid held high; second key is key_b.
    key       = key_a;
    key_valid = 1'b1;
    @(negedge clk);
    key = key_b;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_no_accept_ready", key_ready, 0);
      @(negedge clk);
    end
    chk("b2b_last_idx", rk_idx, 10);
    chk("b2b_last_flag", rk_last, 1);
    chk("b2b_last_rk", rk, exp_rk[10]);
    @(negedge clk);
    chk("b2b_gap_ready", key_ready, 1);
    chk("b2b_gap_valid", rk_valid, 0);
    @(negedge clk);
    key_valid = 1'b0;
    chk("b2b_second_valid", rk_valid, 1);
    chk("b2b_second_idx0", rk_idx, 0);
    chk("b2b_second_rk0", rk, key_b);
    @(negedge clk);
    chk("b2b_second_idx1", rk_idx, 1);
    chk("b2b_second_rk1", rk, 128'hdc9037b0_9b49dfe9_97fe723f_388115a7);
    chk("b2b_second_last", rk_last, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequential AES-128 key-schedule controller. It accepts a 128-bit cipher key over a valid/ready handshake and emits the 11 round keys (round 0 through round 10) one per handshake beat. It computes each key iteratively from the previous one with a single 4-byte S-box bank. It sits between the key-load interface and the round datapath and replaces the fully unrolled combinational expansion (w0..w43) with one 128-bit register stage.

## Interface
Parameters:
- `NR`, default 10: number of rounds. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- `clk`, in, 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `key_valid`, in, 1: `key` is valid.
- `key_ready`, out, 1: block can accept a key. Equals (state == IDLE).
- `key`, in, 128: cipher key, w0 = `key[127:96]` … w3 = `key[31:0]`.
- `rk_valid`, out, 1: `rk` holds a valid round key.
- `rk_ready`, in, 1: consumer accepts `rk`.
- `rk`, out, 128: current round key {w4i, w4i+1, w4i+2, w4i+3}.
- `rk_idx`, out, 4: round index i of `rk`, range 0..10.
- `rk_last`, out, 1: equals (`rk_idx` == NR) while `rk_valid` is high.
- `busy`, out, 1: equals (state == EMIT).

## Operation
- States: IDLE and EMIT.
- IDLE, on `key_valid && key_ready`:
  - `rk` <= `key`, `rk_idx` <= 0, rcon <= 8'h01.
  - Go to EMIT; `rk_valid` <= 1.
- EMIT, on `rk_valid && rk_ready`:
  - If `rk_idx` == NR: go to IDLE and clear `rk_valid`. `rk` and `rk_idx` keep their values.
  - Otherwise:
    - `rk` <= next(`rk`, rcon).
    - `rk_idx` <= `rk_idx` + 1.
    - rcon <= xtime(rcon).
- EMIT without `rk_ready`: `rk`, `rk_idx` and `rk_valid` are held stable. This is a strict AXI-style hold.
- next(): compute t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}. Then:
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- RotWord({a,b,c,d}) = {b,c,d,a}.
- xtime(r) = r[7] ? ((r << 1) ^ 8'h1b) : (r << 1), truncated to 8 bits. This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
- `key_valid` is ignored outside IDLE. A new key is never accepted in the same cycle as the final `rk` handshake.
- Reset values: `key_ready` = 1, `rk_valid` = 0, `rk` = 0, `rk_idx` = 0, `rk_last` = 0, `busy` = 0, internal rcon = 8'h01, state = IDLE.
- Reset asserted mid-EMIT aborts immediately and asynchronously to the reset values. No partial key is emitted after reset release.

## Timing
- Key accepted at edge N: round key 0 is valid after edge N, i.e. in cycle N+1.
- Round key i+1 is valid in the cycle after round key i is accepted. There is one-cycle compute latency, and the S-box bank is combinational between registers.
- With `rk_ready` held high: keys appear in cycles N+1..N+11, and `key_ready` rises in cycle N+12.
- Minimum key-to-key period is 12 cycles.
- `rk_last` and `busy` are combinational from registers and glitch-free relative to `clk`.
- Critical path: w3 → S-box → XOR chain of 4 words.

## Structure
- Package `aes_pkg` holds:
  - `AES_NR` = 10.
  - Typedef `word_t` (32 bits) and typedef `rkey_t` (128 bits).
  - Function `xtime`.
  - The 256-entry S-box constant.
- Sub-module `aes_sbox`: combinational byte-in/byte-out S-box, instantiated 4 times for SubWord. It is reusable by the round datapath.

## Test plan
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c with `rk_ready`=1 -> 11 beats:
  - idx 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - idx 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with `rk_last`=1.
  - `key_ready` high again 12 cycles after accept.
- Key 0f1571c9 47d9e859 0cb7add6 af7f6798 -> idx 1 = dc9037b0 9b49dfe9 97fe723f 388115a7.
- Random `rk_ready` backpressure (~50%) -> `rk` and `rk_idx` hold while stalled. The sequence is identical to the unstalled run, with no skipped or duplicated index.
- `key_valid` pulsed with a different key during EMIT -> ignored; the output stream is unchanged.
- `rst_n` low at idx 5 -> outputs go to reset values immediately. A new key after release restarts at idx 0 with rcon 01.
- Back-to-back keys with `key_valid` held high -> second key accepted exactly in the first IDLE cycle after the idx-10 handshake.
